systolic_input_skewer: RTL

Upstream feeder for the systolic array of int8 processing elements. It accepts row-vectors of N signed bytes over a valid/ready handshake and drives the array's per-row input_byte lanes and its global load and PE_enable controls. Weight bursts are broadcast to the rows unskewed, with load asserted. Activation streams are diagonally skewed, with row r delayed r beats, then flushed with zeros so the array drains.

---
 rtl/systolic_pkg.sv | 17 +
 rtl/systolic_input_skewer_if.sv | 30 +++
 rtl/skew_delay_line.sv | 37 +++
 rtl/systolic_input_skewer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types for the systolic array front end.
// Contents: int8_t lane byte type, skew_state_t state enum,
// ARRAY_N default array dimension.
package systolic_pkg;

  localparam int unsigned ARRAY_N = 4;

  typedef logic signed [7:0] int8_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WEIGHT = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } skew_state_t;

endpackage

// File: rtl/systolic_input_skewer_if.sv
// Upstream beat handshake plus array-side drive signals of the input skewer.
// master: upstream producer (drives in_*, observes everything else)
// slave : skewer (consumes in_*, drives in_ready, array_*, busy, done, err)
interface systolic_input_skewer_if #(
  parameter int unsigned N = 4
);

  logic           in_valid;
  logic           in_ready;
  logic [N*8-1:0] in_data;
  logic           in_is_weight;
  logic           in_last;
  logic [N*8-1:0] array_data;
  logic           array_load;
  logic           array_enable;
  logic           busy;
  logic           done;
  logic           err;

  modport master (
    output in_valid, in_data, in_is_weight, in_last,
    input  in_ready, array_data, array_load, array_enable, busy, done, err
  );

  modport slave (
    input  in_valid, in_data, in_is_weight, in_last,
    output in_ready, array_data, array_load, array_enable, busy, done, err
  );

endinterface

// File: rtl/skew_delay_line.sv
// Byte-wide shift register of DEPTH stages that advances only on en.
// Ports: clk, rst (async, active-high), en (shift), d (byte in),
// q (byte accepted DEPTH enabled cycles earlier).
module skew_delay_line #(
  parameter int unsigned DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] d,
  output logic [7:0] q
);

  logic [DEPTH-1:0][7:0] stages;

  if (DEPTH == 1) begin : g_one
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stages <= '0;
      end else if (en) begin
        stages <= d;
      end
    end
  end else begin : g_multi
    // stages[0] is the newest byte, stages[DEPTH-1] the oldest
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stages <= '0;
      end else if (en) begin
        stages <= {stages[DEPTH-2:0], d};
      end
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/systolic_input_skewer.sv
// Feeds the int8 systolic array: weight bursts are broadcast unskewed with
// load asserted; activation streams are diagonally skewed (row r delayed r
// beats) and then flushed with zeros so the array drains.
// Ports: clk, rst (async, active-high), bus (slave side of
// systolic_input_skewer_if: in_valid/in_ready/in_data/in_is_weight/in_last in,
// array_data/array_load/array_enable/busy/done/err out).
module systolic_input_skewer
  import systolic_pkg::*;
#(
  parameter int unsigned N = ARRAY_N
) (
  input  logic                   clk,
  input  logic                   rst,
  systolic_input_skewer_if.slave bus
);

  localparam int unsigned FLUSH_CYCLES = 2 * N - 1;
  localparam int unsigned FCNT_W       = $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned WCNT_W       = $clog2(N + 1);

  skew_state_t     state;
  logic [FCNT_W-1:0] flush_cnt;
  logic [WCNT_W-1:0] beat_cnt;
  logic              err_q;

  logic           in_ready_c;
  logic           fire;
  logic           flush_mode;
  logic           shift_en;
  logic [N*8-1:0] line_din;
  logic [N*8-1:0] skew_data;
  logic [N*8-1:0] data_c;
  logic           load_c;
  logic           enable_c;
  logic           done_c;

  assign in_ready_c = (state != FLUSH);
  assign fire       = bus.in_valid & in_ready_c;
  assign flush_mode = (state == FLUSH);

  // Zeros are shifted in while draining
  assign line_din = flush_mode ? '0 : bus.in_data;

  // Lane 0 has no delay; lane r sees the byte from r enabled cycles ago
  assign skew_data[7:0] = line_din[7:0];

  for (genvar r = 1; r < int'(N); r++) begin : g_lane
    skew_delay_line #(
      .DEPTH(r)
    ) u_line (
      .clk(clk),
      .rst(rst),
      .en (shift_en),
      .d  (line_din[8*r +: 8]),
      .q  (skew_data[8*r +: 8])
    );
  end

  // Array-side drive decoded from state and the current beat
  always_comb begin
    data_c   = '0;
    load_c   = 1'b0;
    enable_c = 1'b0;
    shift_en = 1'b0;
    done_c   = 1'b0;
    unique case (state)
      IDLE: begin
        if (fire) begin
          enable_c = 1'b1;
          if (bus.in_is_weight) begin
            load_c = 1'b1;
            data_c = bus.in_data;
          end else begin
            shift_en = 1'b1;
            data_c   = skew_data;
          end
        end
      end
      WEIGHT: begin
        if (fire) begin
          enable_c = 1'b1;
          load_c   = 1'b1;
          data_c   = bus.in_data;
        end
      end
      STREAM: begin
        if (fire) begin
          enable_c = 1'b1;
          shift_en = 1'b1;
          data_c   = skew_data;
        end
      end
      FLUSH: begin
        enable_c = 1'b1;
        shift_en = 1'b1;
        data_c   = skew_data;
        done_c   = (flush_cnt == FCNT_W'(FLUSH_CYCLES - 1));
      end
      default: ;
    endcase
  end

  // Control FSM with beat/flush counters and sticky protocol error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
      beat_cnt  <= '0;
      err_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fire) begin
            if (bus.in_is_weight) begin
              state    <= WEIGHT;
              beat_cnt <= WCNT_W'(1);
            end else if (bus.in_last) begin
              state     <= FLUSH;
              flush_cnt <= '0;
            end else begin
              state <= STREAM;
            end
          end
        end
        WEIGHT: begin
          if (fire) begin
            if (!bus.in_is_weight) begin
              err_q <= 1'b1;
            end
            if (beat_cnt == WCNT_W'(N - 1)) begin
              state    <= IDLE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + WCNT_W'(1);
            end
          end
        end
        STREAM: begin
          if (fire) begin
            if (bus.in_is_weight) begin
              err_q <= 1'b1;
            end
            if (bus.in_last) begin
              state     <= FLUSH;
              flush_cnt <= '0;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == FCNT_W'(FLUSH_CYCLES - 1)) begin
            state     <= IDLE;
            flush_cnt <= '0;
          end else begin
            flush_cnt <= flush_cnt + FCNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.array_data   = data_c;
  assign bus.array_load   = load_c;
  assign bus.array_enable = enable_c;
  assign bus.busy         = (state != IDLE);
  assign bus.done         = done_c;
  assign bus.err          = err_q;

endmodule
